// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared loader types and default parameters
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } loader_state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         ADDR_W_DEFAULT = 7;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs hi/lo image bytes into a 16-bit word and keeps the XOR checksum
module word_assembler (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        clr,
  input  logic        hi_en,
  input  logic        lo_en,
  input  logic [7:0]  byte_data,
  output logic [15:0] word,
  output logic [7:0]  csum
);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      word <= '0;
      csum <= '0;
    end else if (clr) begin
      csum <= '0;
    end else if (hi_en) begin
      word[15:8] <= byte_data;
      csum       <= csum ^ byte_data;
    end else if (lo_en) begin
      word[7:0] <= byte_data;
      csum      <= csum ^ byte_data;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader writing 16-bit words into instruction memory
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEFAULT,
  parameter int         ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [7:0]        In_Data,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic              Restart,
  output logic [ADDR_W-1:0] IM_Addr,
  output logic [15:0]       IM_Data,
  output logic              IM_Wr,
  output logic              CPU_Hold,
  output logic              Done,
  output logic              Err
);

  localparam int CW = ADDR_W + 1;

  loader_state_t state, state_nxt;
  logic [CW-1:0] n_words, wcnt, wcnt_inc;
  logic [7:0]    csum;
  logic          accept;

  assign accept   = In_Valid & In_Ready;
  assign wcnt_inc = wcnt + CW'(1);
  assign IM_Addr  = wcnt[ADDR_W-1:0];

  word_assembler u_asm (
    .Clk       (Clk),
    .Reset     (Reset),
    .clr       (state == S_COUNT && accept),
    .hi_en     (state == S_HI && accept),
    .lo_en     (state == S_LO && accept),
    .byte_data (In_Data),
    .word      (IM_Data),
    .csum      (csum)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Count byte 0 means a full 2**ADDR_W-word image, hence the extra counter bit.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      n_words <= '0;
      wcnt    <= '0;
    end else if (state == S_COUNT && accept) begin
      n_words <= (In_Data == 8'h00) ? {1'b1, {ADDR_W{1'b0}}} : CW'(In_Data);
      wcnt    <= '0;
    end else if (state == S_WRITE) begin
      wcnt <= wcnt_inc;
    end
  end

  always_comb begin
    state_nxt = state;
    In_Ready  = 1'b0;
    IM_Wr     = 1'b0;
    CPU_Hold  = 1'b1;
    Done      = 1'b0;
    Err       = 1'b0;
    case (state)
      S_IDLE: begin
        In_Ready = 1'b1;
        if (accept && In_Data == HEADER) state_nxt = S_COUNT;
      end
      S_COUNT: begin
        In_Ready = 1'b1;
        if (accept) state_nxt = S_HI;
      end
      S_HI: begin
        In_Ready = 1'b1;
        if (accept) state_nxt = S_LO;
      end
      S_LO: begin
        In_Ready = 1'b1;
        if (accept) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        IM_Wr     = 1'b1;
        state_nxt = (wcnt_inc == n_words) ? S_CHECK : S_HI;
      end
      S_CHECK: begin
        In_Ready = 1'b1;
        if (accept) state_nxt = (In_Data == csum) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        Done     = 1'b1;
        CPU_Hold = 1'b0;
        if (Restart) state_nxt = S_IDLE;
      end
      S_ERR: begin
        Err = 1'b1;
        if (Restart) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [7:0]  In_Data = '0;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic        Restart = 1'b0;
  logic [6:0]  IM_Addr;
  logic [15:0] IM_Data;
  logic        IM_Wr;
  logic        CPU_Hold;
  logic        Done;
  logic        Err;

  int tests = 0;
  int failed = 0;
  int wr_ready_bad = 0;
  logic [6:0]  wr_addr[$];
  logic [15:0] wr_data[$];
  bit          rand_gap = 1'b0;

  prog_loader dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .In_Data  (In_Data),
    .In_Valid (In_Valid),
    .In_Ready (In_Ready),
    .Restart  (Restart),
    .IM_Addr  (IM_Addr),
    .IM_Data  (IM_Data),
    .IM_Wr    (IM_Wr),
    .CPU_Hold (CPU_Hold),
    .Done     (Done),
    .Err      (Err)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Reset && IM_Wr) begin
      wr_addr.push_back(IM_Addr);
      wr_data.push_back(IM_Data);
      if (In_Ready) wr_ready_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bit ok = 1'b0;
    if (rand_gap) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge Clk);
        In_Valid = 1'b0;
        In_Data  = 8'($urandom);
      end
    end
    @(negedge Clk);
    In_Valid = 1'b1;
    In_Data  = b;
    for (int t = 0; t < 50; t++) begin
      if (In_Ready) begin
        @(posedge Clk);
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_bus();
    @(negedge Clk);
    In_Valid = 1'b0;
    In_Data  = 8'h00;
  endtask

  task automatic pulse_restart();
    @(negedge Clk);
    Restart = 1'b1;
    @(negedge Clk);
    Restart = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(In_Ready), 32'd1);
    check({tag, "_wr"},    32'(IM_Wr),    32'd0);
    check({tag, "_addr"},  32'(IM_Addr),  32'd0);
    check({tag, "_data"},  32'(IM_Data),  32'd0);
    check({tag, "_hold"},  32'(CPU_Hold), 32'd1);
    check({tag, "_done"},  32'(Done),     32'd0);
    check({tag, "_err"},   32'(Err),      32'd0);
  endtask

  task automatic check_two_word_image(input string tag);
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check({tag, "_a0"}, 32'(wr_addr[0]), 32'h0);
      check({tag, "_d0"}, 32'(wr_data[0]), 32'h1234);
      check({tag, "_a1"}, 32'(wr_addr[1]), 32'h1);
      check({tag, "_d1"}, 32'(wr_data[1]), 32'hABCD);
    end
  endtask

  initial begin
    // reset state
    #2;
    check_reset_outputs("rst");
    @(negedge Clk);
    Reset = 1'b1;

    // two-word image, good checksum
    clear_log();
    send(8'hA5); send(8'h02); send(8'h12); send(8'h34);
    send(8'hAB); send(8'hCD); send(8'h40);
    idle_bus();
    check_two_word_image("good");
    check("good_done", 32'(Done), 32'd1);
    check("good_err",  32'(Err), 32'd0);
    check("good_hold", 32'(CPU_Hold), 32'd0);
    check("good_ready", 32'(In_Ready), 32'd0);
    pulse_restart();
    check("rs1_done", 32'(Done), 32'd0);
    check("rs1_hold", 32'(CPU_Hold), 32'd1);
    check("rs1_ready", 32'(In_Ready), 32'd1);

    // same image, bad checksum
    clear_log();
    send(8'hA5); send(8'h02); send(8'h12); send(8'h34);
    send(8'hAB); send(8'hCD); send(8'h41);
    idle_bus();
    check_two_word_image("bad");
    check("bad_err",  32'(Err), 32'd1);
    check("bad_done", 32'(Done), 32'd0);
    check("bad_hold", 32'(CPU_Hold), 32'd1);
    pulse_restart();
    check("rs2_err", 32'(Err), 32'd0);
    check("rs2_ready", 32'(In_Ready), 32'd1);

    // leading junk discarded; Restart during COUNT ignored
    clear_log();
    send(8'h00); send(8'hFF); send(8'hA5);
    idle_bus();
    pulse_restart();
    send(8'h01); send(8'h00); send(8'h07); send(8'h07);
    idle_bus();
    check("one_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("one_a0", 32'(wr_addr[0]), 32'h0);
      check("one_d0", 32'(wr_data[0]), 32'h0007);
    end
    check("one_done", 32'(Done), 32'd1);
    pulse_restart();

    // count byte 0: 128 words 0x0001..0x0080, checksum 0x80
    clear_log();
    send(8'hA5); send(8'h00);
    for (int i = 1; i <= 128; i++) begin
      send(8'h00);
      send(8'(i));
    end
    send(8'h80);
    idle_bus();
    check("full_nwr", 32'(wr_addr.size()), 32'd128);
    if (wr_addr.size() == 128) begin
      check("full_a0",   32'(wr_addr[0]),   32'd0);
      check("full_d0",   32'(wr_data[0]),   32'h0001);
      check("full_a127", 32'(wr_addr[127]), 32'd127);
      check("full_d127", 32'(wr_data[127]), 32'h0080);
    end
    check("full_done", 32'(Done), 32'd1);
    pulse_restart();

    // reset mid-load after the HI byte of word 3
    clear_log();
    send(8'hA5); send(8'h05);
    send(8'h01); send(8'h11); send(8'h02); send(8'h22); send(8'h03); send(8'h33);
    send(8'h44);
    @(negedge Clk);
    In_Valid = 1'b0;
    Reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_nwr", 32'(wr_addr.size()), 32'd3);
    @(negedge Clk);
    Reset = 1'b1;
    clear_log();
    send(8'hA5); send(8'h01); send(8'hBE); send(8'hEF); send(8'h51);
    idle_bus();
    check("reload_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("reload_a0", 32'(wr_addr[0]), 32'h0);
      check("reload_d0", 32'(wr_data[0]), 32'hBEEF);
    end
    check("reload_done", 32'(Done), 32'd1);
    pulse_restart();

    // random In_Valid gaps on the two-word image
    clear_log();
    wr_ready_bad = 0;
    rand_gap = 1'b1;
    send(8'hA5); send(8'h02); send(8'h12); send(8'h34);
    send(8'hAB); send(8'hCD); send(8'h40);
    rand_gap = 1'b0;
    idle_bus();
    check_two_word_image("gap");
    check("gap_done", 32'(Done), 32'd1);
    check("gap_ready_in_write", 32'(wr_ready_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter HEADER, default 8'hA5, start-of-image marker byte.
REQ-002 Parameter ADDR_W, default 7, instruction memory address width (matches PC_Out width).
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 In_Data  input  8  incoming image byte.
REQ-006 In_Valid  input  1  In_Data valid this cycle.
REQ-007 In_Ready  output  1  loader accepts a byte this cycle.
REQ-008 Restart  input  1  single-cycle pulse; re-arms the loader from DONE or ERR.
REQ-009 IM_Addr  output  ADDR_W  instruction memory write address.
REQ-010 IM_Data  output  16  instruction memory write data.
REQ-011 IM_Wr  output  1  instruction memory write strobe, one cycle per word.
REQ-012 CPU_Hold  output  1  holds the control unit in reset while high.
REQ-013 Done  output  1  image loaded and checksum matched.
REQ-014 Err  output  1  checksum mismatch detected.

Function
REQ-015 A byte SHALL transfer only on a rising edge where In_Valid and In_Ready are both 1; In_Data is ignored otherwise.
REQ-016 States SHALL be IDLE, COUNT, HI, LO, WRITE, CHECK, DONE, ERR; In_Ready=1 in IDLE, COUNT, HI, LO, CHECK and 0 elsewhere.
REQ-017 IDLE: accepted byte equal to HEADER -> COUNT; any other byte is discarded and the loader stays in IDLE with no error.
REQ-018 COUNT: accepted byte latched as word count N (0 encodes 2**ADDR_W = 128) -> HI; word address counter cleared to 0, checksum cleared to 0.
REQ-019 HI: accepted byte -> IM_Data[15:8] -> LO; LO: accepted byte -> IM_Data[7:0] -> WRITE.
REQ-020 Every accepted HI/LO byte SHALL be XORed into the 8-bit running checksum.
REQ-021 WRITE SHALL last exactly one cycle with IM_Wr=1, IM_Addr = word counter and IM_Data = assembled word; the counter then increments.
REQ-022 After WRITE: if N words written -> CHECK, else -> HI.
REQ-023 Word counter SHALL be ADDR_W+1 bits wide so N=128 terminates correctly; IM_Addr is its low ADDR_W bits and never exceeds 127.
REQ-024 CHECK: accepted byte equal to the running checksum -> DONE, otherwise -> ERR.
REQ-025 DONE: Done=1, CPU_Hold=0; ERR: Err=1, CPU_Hold=1; both hold until Restart.
REQ-026 Restart in DONE or ERR -> IDLE with Done=0, Err=0, CPU_Hold=1; Restart in any other state is ignored.
REQ-027 Restart coinciding with an accepted byte is impossible (In_Ready=0 in DONE/ERR) and needs no priority rule.
REQ-028 CPU_Hold SHALL be 1 in every state except DONE.
REQ-029 IM_Wr SHALL be 0 outside WRITE; IM_Addr/IM_Data may hold stale values when IM_Wr=0.

Reset
REQ-030 Reset low SHALL immediately force IDLE, In_Ready=1, IM_Wr=0, IM_Addr=0, IM_Data=0, CPU_Hold=1, Done=0, Err=0, counter=0, checksum=0.
REQ-031 Reset asserted mid-load SHALL abandon the image; words already written remain in memory and are not rewritten.
REQ-032 After Reset deasserts, the first rising edge SHALL already evaluate IDLE behaviour.

Structure
REQ-033 State enum (loader_state_t), HEADER default and ADDR_W default SHALL live in the shared processor package.
REQ-034 The byte-to-word assembler plus checksum SHALL be one sub-module, word_assembler; the FSM and counters stay in prog_loader.

Verification
REQ-035 Bytes A5,02,12,34,AB,CD,checksum 40 -> IM_Wr pulses at addr 0 data 1234 and addr 1 data ABCD, then Done=1, CPU_Hold=0.
REQ-036 Same image with checksum 41 -> both writes occur, then Err=1, CPU_Hold=1; Restart pulse -> IDLE, Err=0.
REQ-037 Bytes 00,FF,A5,01,00,07,07 -> leading 00,FF discarded, one write addr 0 data 0007, Done=1.
REQ-038 Count byte 00 with 128 words of 0x0001..0x0080 -> 128 writes, last at addr 127 data 0080, correct checksum -> Done=1.
REQ-039 Reset asserted after the HI byte of word 3 -> outputs at REQ-030 values within the same cycle; new image loads from addr 0.
REQ-040 In_Valid toggled randomly during 02-word image -> identical writes and Done as REQ-035; In_Ready=0 during every WRITE cycle.
